// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel post-processing stream stages.
package sobel_pkg;

  localparam int PIX_W      = 8;
  localparam int BORDER     = 2;
  localparam int DIR_RATIO_A = 5;
  localparam int DIR_RATIO_B = 2;

  typedef logic signed [2*PIX_W-1:0] grad_t;
  typedef logic [PIX_W-1:0]          mag_t;

  typedef enum logic [1:0] {
    DIR_H   = 2'd0,
    DIR_45  = 2'd1,
    DIR_V   = 2'd2,
    DIR_135 = 2'd3
  } dir_e;

endpackage

// File: rtl/raster_counter.sv
// Column/row raster tracker advanced once per accepted beat; flags describe the
// position of the beat currently being offered.
module raster_counter
  import sobel_pkg::*;
#(
  parameter int W_P      = 16,
  parameter int H_P      = 16,
  parameter int BORDER_P = BORDER,
  parameter int CW_P     = (W_P > 1) ? $clog2(W_P) : 1,
  parameter int RW_P     = (H_P > 1) ? $clog2(H_P) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic adv_i,
  output logic eol_o,
  output logic eof_o,
  output logic border_o
);

  logic [CW_P-1:0] r_col;
  logic [RW_P-1:0] r_row;

  assign eol_o    = (r_col == CW_P'(W_P - 1));
  assign eof_o    = eol_o && (r_row == RW_P'(H_P - 1));
  assign border_o = (r_col < CW_P'(BORDER_P)) || (r_row < RW_P'(BORDER_P));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_col <= '0;
      r_row <= '0;
    end else if (adv_i) begin
      if (eol_o) begin
        r_col <= '0;
        r_row <= eof_o ? '0 : r_row + RW_P'(1);
      end else begin
        r_col <= r_col + CW_P'(1);
      end
    end
  end

endmodule

// File: rtl/sobel_magnitude.sv
// L1 gradient magnitude with border blanking, edge threshold and eol/eof tags; 2-cycle
// valid/ready pipeline. SOBEL_MAG_DIR_EN adds a quantised direction output dir_o.
module sobel_magnitude
  import sobel_pkg::*;
#(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 16,
  parameter int IMG_H_P = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic signed [2*WIDTH_P-1:0] gx_i,
  input  logic signed [2*WIDTH_P-1:0] gy_i,
  input  logic        [WIDTH_P-1:0]   thresh_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic        [WIDTH_P-1:0]   mag_o,
  output logic                        edge_o,
  output logic                        eol_o,
`ifdef SOBEL_MAG_DIR_EN
  output logic                        eof_o,
  output logic        [1:0]           dir_o
`else
  output logic                        eof_o
`endif
);

  localparam int GW = 2 * WIDTH_P;
  localparam int AW = GW + 1;
  localparam int SW = GW + 2;
  localparam logic [SW-1:0] SAT_MAX = SW'((1 << WIDTH_P) - 1);

  logic w_en1, w_en2, w_acc;
  logic w_eol, w_eof, w_border;
  logic [AW-1:0] w_gx_ext, w_gy_ext, w_ax, w_ay;
  logic [SW-1:0] w_sum;
  logic [WIDTH_P-1:0] w_sat, w_mag;
  logic w_edge;

  logic r_v1, r_border, r_eol1, r_eof1;
  logic [AW-1:0] r_ax, r_ay;
  logic r_v2, r_edge, r_eol2, r_eof2;
  logic [WIDTH_P-1:0] r_mag;

  // ready_i feeds ready_o combinationally so a full pipe still moves every cycle
  assign w_en2   = !r_v2 || ready_i;
  assign w_en1   = !r_v1 || w_en2;
  assign ready_o = w_en1;
  assign w_acc   = valid_i && w_en1;

  raster_counter #(
    .W_P      (IMG_W_P),
    .H_P      (IMG_H_P),
    .BORDER_P (BORDER)
  ) u_raster (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (w_acc),
    .eol_o    (w_eol),
    .eof_o    (w_eof),
    .border_o (w_border)
  );

  // One extra bit keeps |most negative| exact
  assign w_gx_ext = {gx_i[GW-1], gx_i};
  assign w_gy_ext = {gy_i[GW-1], gy_i};
  assign w_ax     = w_gx_ext[AW-1] ? (~w_gx_ext + AW'(1)) : w_gx_ext;
  assign w_ay     = w_gy_ext[AW-1] ? (~w_gy_ext + AW'(1)) : w_gy_ext;

  assign w_sum  = SW'(r_ax) + SW'(r_ay);
  assign w_sat  = (w_sum > SAT_MAX) ? {WIDTH_P{1'b1}} : w_sum[WIDTH_P-1:0];
  assign w_mag  = r_border ? '0 : w_sat;
  assign w_edge = !r_border && (w_sat >= thresh_i);

`ifdef SOBEL_MAG_DIR_EN
  localparam int DW = AW + 3;
  logic r_sgn_diff;
  logic [1:0] r_dir;
  logic [DW-1:0] w_ay_a, w_ax_b, w_ax_a, w_ay_b;
  dir_e w_dir;

  assign w_ay_a = DW'(r_ay) * DW'(DIR_RATIO_A);
  assign w_ax_b = DW'(r_ax) * DW'(DIR_RATIO_B);
  assign w_ax_a = DW'(r_ax) * DW'(DIR_RATIO_A);
  assign w_ay_b = DW'(r_ay) * DW'(DIR_RATIO_B);

  always_comb begin
    w_dir = DIR_H;
    if (r_border || (r_ax == '0 && r_ay == '0)) w_dir = DIR_H;
    else if (w_ay_a < w_ax_b)                   w_dir = DIR_H;
    else if (w_ax_a < w_ay_b)                   w_dir = DIR_V;
    else if (!r_sgn_diff)                       w_dir = DIR_45;
    else                                        w_dir = DIR_135;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sgn_diff <= 1'b0;
      r_dir      <= '0;
    end else begin
      if (w_acc) r_sgn_diff <= gx_i[GW-1] ^ gy_i[GW-1];
      if (w_en2) r_dir <= r_v1 ? w_dir : '0;
    end
  end

  assign dir_o = r_dir;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v1     <= 1'b0;
      r_ax     <= '0;
      r_ay     <= '0;
      r_border <= 1'b0;
      r_eol1   <= 1'b0;
      r_eof1   <= 1'b0;
      r_v2     <= 1'b0;
      r_mag    <= '0;
      r_edge   <= 1'b0;
      r_eol2   <= 1'b0;
      r_eof2   <= 1'b0;
    end else begin
      if (w_en1) begin
        r_v1 <= w_acc;
        if (w_acc) begin
          r_ax     <= w_ax;
          r_ay     <= w_ay;
          r_border <= w_border;
          r_eol1   <= w_eol;
          r_eof1   <= w_eof;
        end
      end
      // An empty S1 loads zeros so idle outputs read 0
      if (w_en2) begin
        r_v2   <= r_v1;
        r_mag  <= r_v1 ? w_mag : '0;
        r_edge <= r_v1 && w_edge;
        r_eol2 <= r_v1 && r_eol1;
        r_eof2 <= r_v1 && r_eof1;
      end
    end
  end

  assign valid_o = r_v2;
  assign mag_o   = r_mag;
  assign edge_o  = r_edge;
  assign eol_o   = r_eol2;
  assign eof_o   = r_eof2;

endmodule

// File: tb/tb_sobel_magnitude.sv
// Randomised bench for sobel_magnitude against a raster/arithmetic reference model.
module tb_sobel_magnitude;

  localparam int W  = 8;
  localparam int IW = 16;
  localparam int IH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_i, valid_i, ready_o, valid_o, ready_i, edge_o, eol_o, eof_o;
  logic signed [2*W-1:0] gx_i, gy_i;
  logic [W-1:0] thresh_i, mag_o;
`ifdef SOBEL_MAG_DIR_EN
  logic [1:0] dir_o;
`endif

  sobel_magnitude #(.WIDTH_P(W), .IMG_W_P(IW), .IMG_H_P(IH)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .gx_i     (gx_i),
    .gy_i     (gy_i),
    .thresh_i (thresh_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .mag_o    (mag_o),
    .edge_o   (edge_o),
    .eol_o    (eol_o),
`ifdef SOBEL_MAG_DIR_EN
    .eof_o    (eof_o),
    .dir_o    (dir_o)
`else
    .eof_o    (eof_o)
`endif
  );

  typedef struct {
    int mag;
    bit edg;
    bit eol;
    bit eof;
    int dir;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int m_col = 0, m_row = 0;
  int acc_cnt = 0, out_cnt = 0, out_since_rst = 0;
  int n_edge = 0, n_eof = 0;
  bit p_stall = 0;
  logic [W-1:0] p_mag;
  logic p_edge, p_eol, p_eof;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint gx, input longint gy, input int col,
                                 input int row, input int th);
    exp_t e;
    longint ax, ay, sum;
    bit border;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    sum = ax + ay;
    border = (col < 2) || (row < 2);
    e.mag = border ? 0 : ((sum > 255) ? 255 : int'(sum));
    e.edg = !border && (e.mag >= th);
    e.eol = (col == IW - 1);
    e.eof = e.eol && (row == IH - 1);
    if (border || (ax == 0 && ay == 0)) e.dir = 0;
    else if (5 * ay < 2 * ax)           e.dir = 0;
    else if (5 * ax < 2 * ay)           e.dir = 2;
    else if ((gx < 0) == (gy < 0))      e.dir = 1;
    else                                e.dir = 3;
    return e;
  endfunction

  // Observe transfers away from the clock edge; queue accepted beats, retire emitted ones
  always @(negedge clk) begin
    if (rst_i) begin
      q.delete();
      m_col = 0;
      m_row = 0;
      out_since_rst = 0;
      p_stall = 0;
    end else begin
      if (p_stall) begin
        check("stall_vld", valid_o, 1);
        check("stall_mag", mag_o, p_mag);
        check("stall_edge", edge_o, p_edge);
        check("stall_eol", eol_o, p_eol);
        check("stall_eof", eof_o, p_eof);
      end
      if (!valid_o) begin
        check("idle_mag", mag_o, 0);
        check("idle_flags", {edge_o, eol_o, eof_o}, 0);
      end else if (ready_i) begin
        if (q.size() == 0) begin
          check("out_without_in", valid_o, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("mag", mag_o, e.mag);
          check("edge", edge_o, e.edg);
          check("eol", eol_o, e.eol);
          check("eof", eof_o, e.eof);
          check("eof_pos", eof_o, ((out_since_rst % (IW * IH)) == IW * IH - 1) ? 1 : 0);
`ifdef SOBEL_MAG_DIR_EN
          check("dir", dir_o, e.dir);
`endif
          out_since_rst++;
          out_cnt++;
          if (edge_o) n_edge++;
          if (eof_o) n_eof++;
        end
      end
      if (valid_i && ready_o) begin
        q.push_back(model(longint'(gx_i), longint'(gy_i), m_col, m_row, int'(thresh_i)));
        acc_cnt++;
        if (m_col == IW - 1) begin
          m_col = 0;
          m_row = (m_row == IH - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
      p_stall = valid_o && !ready_i;
      p_mag = mag_o;
      p_edge = edge_o;
      p_eol = eol_o;
      p_eof = eof_o;
    end
  end

  task automatic gen(input int mode, input int k);
    case (mode)
      0: begin gx_i = 16'sd3; gy_i = -16'sd4; end
      1: begin gx_i = -16'sd32768; gy_i = 16'sd32767; end
      2: begin
        if ($urandom_range(1) == 0) begin
          gx_i = 16'($urandom_range(600) - 300);
          gy_i = 16'($urandom_range(600) - 300);
        end else begin
          gx_i = 16'($urandom());
          gy_i = 16'($urandom());
        end
      end
      default: begin
        case (k % 5)
          0: begin gx_i = 16'sd10; gy_i = 16'sd1; end
          1: begin gx_i = 16'sd1;  gy_i = 16'sd10; end
          2: begin gx_i = 16'sd5;  gy_i = 16'sd5; end
          3: begin gx_i = 16'sd5;  gy_i = -16'sd5; end
          default: begin gx_i = 16'sd0; gy_i = 16'sd0; end
        endcase
      end
    endcase
  endtask

  task automatic drive(input int nbeats, input int mode, input int pv, input int pr);
    int target, budget, k;
    target = acc_cnt + nbeats;
    budget = nbeats * 20 + 100;
    k = 0;
    forever begin
      @(posedge clk); #1;
      if (acc_cnt >= target) begin
        valid_i = 1'b0;
        break;
      end
      if (budget == 0) begin
        check("drive_timeout", acc_cnt, target);
        valid_i = 1'b0;
        break;
      end
      valid_i = ($urandom_range(99) < pv);
      ready_i = ($urandom_range(99) < pr);
      gen(mode, k);
      k++;
      budget--;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    valid_i = 1'b0;
    ready_i = 1'b1;
    while ((q.size() != 0 || valid_o) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_left", q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    gx_i = '0; gy_i = '0; thresh_i = 8'd7;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid_o", valid_o, 0);
    check("rst_mag_o", mag_o, 0);
    check("rst_edge_o", edge_o, 0);
    check("rst_eol_eof", {eol_o, eof_o}, 0);
    check("rst_ready_o", ready_o, 1);

    // Full frame of constant gradient (3,-4): interior mag 7, edge 1
    n_edge = 0; n_eof = 0; base = out_cnt;
    drive(IW * IH, 0, 100, 100);
    drain();
    check("frame1_count", out_cnt - base, IW * IH);
    check("frame1_edges", n_edge, (IW - 2) * (IH - 2));
    check("frame1_eofs", n_eof, 1);

    // Extreme gradients saturate to 255
    thresh_i = 8'd200;
    n_edge = 0;
    drive(IW * IH, 1, 100, 100);
    drain();
    check("sat_edges", n_edge, (IW - 2) * (IH - 2));

    // Random data with random valid/ready
    thresh_i = 8'($urandom_range(255));
    drive(300, 2, 70, 60);
    drain();
    thresh_i = 8'd0;
    drive(200, 2, 80, 50);
    drain();

    // Output stall for 5 cycles under continuous input
    thresh_i = 8'd50;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b1;
      ready_i = !(i >= 8 && i < 13);
      gen(2, i);
      @(negedge clk);
      if (i == 12) check("stall_ready_o", ready_o, 0);
      if (i >= 14 && i < 20) check("gapfree_vld", valid_o, 1);
    end
    @(posedge clk); #1;
    drain();

    // Reset at beat 100 discards in-flight beats and realigns the raster
    pulse_reset();
    drive(100, 2, 100, 100);
    pulse_reset();
    @(negedge clk);
    check("midrst_valid_o", valid_o, 0);
    thresh_i = 8'd7;
    n_edge = 0; n_eof = 0; base = out_cnt;
    drive(IW * IH, 0, 100, 100);
    drain();
    check("postrst_count", out_cnt - base, IW * IH);
    check("postrst_edges", n_edge, (IW - 2) * (IH - 2));
    check("postrst_eofs", n_eof, 1);

`ifdef SOBEL_MAG_DIR_EN
    thresh_i = 8'd3;
    drive(3 * IW, 3, 100, 100);
    drain();
`endif

    check("final_queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
